pwm_multichannel_gen: RTL
=========================

Name: pwm_multichannel_gen

Overview:
Parametrised successor to the single-channel PWM generator. It drives CHANNELS independent PWM outputs from one shared prescaler and one shared period counter. Each channel has its own duty register, adjusted by active-low sum/rest push-buttons aimed at the channel chosen by ch_sel. New duty values are applied only at period boundaries, so the outputs never glitch. The block sits between the front-panel button/selector logic and the BCD display converter.

Parameters:
CHANNELS, 4, number of PWM outputs (1..16)
FRECUENCY_BITS, 3, prescaler width; one counter tick every 2^FRECUENCY_BITS clocks
RESOLUTION_BITS, 8, width of the period counter and of each duty register
SEL_BITS, 2, width of ch_sel; must satisfy 2^SEL_BITS >= CHANNELS

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
sum  input  1  increment button, active low, asynchronous to clk
rest  input  1  decrement button, active low, asynchronous to clk
ch_sel  input  SEL_BITS  channel targeted by sum/rest
ena  output  1  prescaler tick, one clk wide
value  output  RESOLUTION_BITS  current period counter
pwm_out  output  CHANNELS  PWM outputs; bit c belongs to channel c
referencia  output  RESOLUTION_BITS  pending (shadow) duty of the selected channel
enaSel  output  1  one-clk pulse when any shadow duty changes
period_start  output  1  one-clk pulse when value wraps to 0

Behaviour:
- Reset (rst=0, asynchronous) clears all registers. Outputs reset to: ena=0, value=0, pwm_out=0, referencia=0, enaSel=0, period_start=0. All shadow and active duties reset to 0. Synchronizers reset to 1 (idle).
- Prescaler:
  - FRECUENCY_BITS-bit free-running counter.
  - ena=1 during the clk cycle in which the prescaler equals all-ones.
- Period counter:
  - value increments on each ena.
  - Wraps from 2^RESOLUTION_BITS-1 to 0.
  - On that wrap, period_start pulses for 1 clk, coincident with the ena that caused the wrap.
- Buttons:
  - Each of sum and rest passes through a 2-FF synchronizer, then a falling-edge detector (sync2=0, previous sync2=1).
  - One press causes exactly one step; holding the button does nothing further.
  - The shadow duty updates on the 3rd rising clk edge after the input falls.
- Duty update:
  - A sum edge adds 1 to shadow[ch_sel] and saturates at 2^RESOLUTION_BITS-1.
  - A rest edge subtracts 1 and saturates at 0.
  - A sum edge and a rest edge in the same cycle cause no change.
  - ch_sel >= CHANNELS causes no change.
  - enaSel pulses in the same cycle as the shadow register update, and only if the value actually changed (no pulse at saturation).
- Shadow-to-active transfer:
  - All channels copy shadow to active in the cycle of period_start.
  - A change made mid-period takes effect at the next period start.
  - A shadow update in the period_start cycle itself: the old shadow is transferred, and the new value applies one period later.
- Output compare: pwm_out[c] = (value < active[c]), registered, so there is 1 clk latency after value changes.
  - active=0 keeps the output low for the whole period.
  - active=2^RESOLUTION_BITS-1 keeps it high for all ticks except the last one.
- referencia = shadow[ch_sel], combinational from registers. It reads 0 when ch_sel >= CHANNELS.
- Reset mid-period or mid-press clears everything immediately. A button still held low when reset is released produces no step until it is released and pressed again.

Optional Feature:
PWM_CENTER_ALIGN_EN
- Defined: value counts up from 0 to 2^RESOLUTION_BITS-1, then down to 0, as a triangle. Period is 2*(2^RESOLUTION_BITS-1) ticks.
  - period_start pulses at the valley (value returns to 0).
  - The shadow transfer happens at the valley.
  - pwm_out[c] = (value < active[c]), giving symmetric pulses of 2*active[c]-1 ticks, or 0 ticks when active=0.
- Undefined: edge-aligned sawtooth as described in Behaviour.

Test Plan:
1. Reset behaviour: rst low for 2 clk with sum low → all outputs 0. After rst rises with sum still low, no enaSel until sum rises and falls again.
2. Single press: defaults, ch_sel=1, sum low for 50 clk → shadow[1]=1 on the 3rd edge, enaSel pulses once, referencia=1. At the next period_start, pwm_out[1] is high for 8 clk out of every 2048. Other channels stay low.
3. Saturation: 255 sum presses on ch 0, then 1 more → shadow stays 255 with no enaSel on the extra press. 256 rest presses → shadow reaches 0, with no enaSel on the last press.
4. Glitch-free update: set ch 2 to 128, then press sum at value=200 → pwm_out[2] keeps 1024 clk high in the current period, and 1032 clk high from the next period_start on.
5. Simultaneous and invalid inputs: sum and rest falling on the same clk → no change, no enaSel. ch_sel=3 with CHANNELS=3, sum pressed → no change, referencia=0.
6. With PWM_CENTER_ALIGN_EN, duty 64 → pwm_out high for 127 ticks (1016 clk) centred on the valley, in a period of 510 ticks (4080 clk).

Source files
------------

// File: rtl/pwm_multichannel_gen_if.sv
// -----------------------------------------------------------------------------
// pwm_multichannel_gen_if
// Bundles the front-panel controls and the PWM/status outputs of
// pwm_multichannel_gen. clk and rst stay plain ports of the generator.
//
// Signals:
//   sum          : increment button, active low, asynchronous to clk
//   rest         : decrement button, active low, asynchronous to clk
//   ch_sel       : channel targeted by sum/rest
//   ena          : prescaler tick, one clk wide
//   value        : current period counter
//   pwm_out      : PWM outputs, bit c belongs to channel c
//   referencia   : pending (shadow) duty of the selected channel
//   enaSel       : one-clk pulse when a shadow duty changes
//   period_start : one-clk pulse when the period restarts
//
// Modports:
//   master : front-panel side (drives the buttons and selector)
//   slave  : the PWM generator
// -----------------------------------------------------------------------------
interface pwm_multichannel_gen_if #(
    parameter int CHANNELS        = 4,
    parameter int RESOLUTION_BITS = 8,
    parameter int SEL_BITS        = 2
);
    logic                       sum;
    logic                       rest;
    logic [SEL_BITS-1:0]        ch_sel;
    logic                       ena;
    logic [RESOLUTION_BITS-1:0] value;
    logic [CHANNELS-1:0]        pwm_out;
    logic [RESOLUTION_BITS-1:0] referencia;
    logic                       enaSel;
    logic                       period_start;

    modport master (
        output sum, rest, ch_sel,
        input  ena, value, pwm_out, referencia, enaSel, period_start
    );

    modport slave (
        input  sum, rest, ch_sel,
        output ena, value, pwm_out, referencia, enaSel, period_start
    );
endinterface

// File: rtl/pwm_multichannel_gen.sv
// -----------------------------------------------------------------------------
// pwm_multichannel_gen
// CHANNELS independent PWM outputs driven from one shared prescaler and one
// shared period counter. Each channel owns a shadow duty (edited by the
// sum/rest push-buttons on the channel picked by ch_sel) and an active duty
// (used by the comparator). Shadow is copied to active only at the period
// start, so an output never glitches mid-period.
//
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : pwm_multichannel_gen_if.slave
//         inputs  sum, rest (active-low buttons), ch_sel
//         outputs ena, value, pwm_out, referencia, enaSel, period_start
//
// Build option:
//   PWM_CENTER_ALIGN_EN : when defined the period counter runs as a triangle
//   (0 up to max, back down to 0) giving centre-aligned pulses; when
//   undefined it is an edge-aligned sawtooth.
// -----------------------------------------------------------------------------
module pwm_multichannel_gen #(
    parameter int CHANNELS        = 4,
    parameter int FRECUENCY_BITS  = 3,
    parameter int RESOLUTION_BITS = 8,
    parameter int SEL_BITS        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    pwm_multichannel_gen_if.slave bus
);

    localparam logic [RESOLUTION_BITS-1:0] DUTY_MAX = '1;
    localparam logic [RESOLUTION_BITS-1:0] DUTY_ONE = RESOLUTION_BITS'(1);

    function automatic logic [RESOLUTION_BITS-1:0] sat_inc(
        input logic [RESOLUTION_BITS-1:0] d
    );
        return (d == DUTY_MAX) ? d : d + DUTY_ONE;
    endfunction

    function automatic logic [RESOLUTION_BITS-1:0] sat_dec(
        input logic [RESOLUTION_BITS-1:0] d
    );
        return (d == '0) ? d : d - DUTY_ONE;
    endfunction

    logic [FRECUENCY_BITS-1:0]  r_presc;
    logic [RESOLUTION_BITS-1:0] r_value;
    logic [CHANNELS-1:0]        r_pwm;
    logic                       r_enaSel;
    logic [RESOLUTION_BITS-1:0] r_shadow [CHANNELS];
    logic [RESOLUTION_BITS-1:0] r_active [CHANNELS];

    logic r_sum_s1, r_sum_s2, r_sum_prev;
    logic r_rest_s1, r_rest_s2, r_rest_prev;
    logic [1:0] r_warm;

`ifdef PWM_CENTER_ALIGN_EN
    logic r_down;
`endif

    logic                       w_ena;
    logic                       w_wrap;
    logic                       w_sum_fall;
    logic                       w_rest_fall;
    logic                       w_step_up;
    logic                       w_step_dn;
    logic                       w_sel_valid;
    logic [RESOLUTION_BITS-1:0] w_sel_duty;
    logic [RESOLUTION_BITS-1:0] w_next_duty;
    logic                       w_duty_change;

    // ---------------- prescaler ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + FRECUENCY_BITS'(1);
        end
    end

    assign w_ena = &r_presc;

    // ---------------- period counter ----------------
`ifdef PWM_CENTER_ALIGN_EN
    // Valley is reached on the downward tick from 1 to 0.
    assign w_wrap = w_ena & r_down & (r_value == DUTY_ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= '0;
            r_down  <= 1'b0;
        end else if (w_ena) begin
            if (!r_down) begin
                if (r_value == DUTY_MAX) begin
                    r_down  <= 1'b1;
                    r_value <= r_value - DUTY_ONE;
                end else begin
                    r_value <= r_value + DUTY_ONE;
                end
            end else begin
                if (r_value == DUTY_ONE) begin
                    r_down <= 1'b0;
                end
                r_value <= r_value - DUTY_ONE;
            end
        end
    end
`else
    assign w_wrap = w_ena & (r_value == DUTY_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= '0;
        end else if (w_ena) begin
            r_value <= r_value + DUTY_ONE;
        end
    end
`endif

    // ---------------- button synchronisers / edge detect ----------------
    // r_warm gates the edge detectors until the synchronisers hold real
    // samples, and the prev registers start at 0: a button still held low
    // across reset release therefore never looks like a fresh press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum_s1    <= 1'b1;
            r_sum_s2    <= 1'b1;
            r_rest_s1   <= 1'b1;
            r_rest_s2   <= 1'b1;
            r_sum_prev  <= 1'b0;
            r_rest_prev <= 1'b0;
            r_warm      <= 2'b00;
        end else begin
            r_sum_s1    <= bus.sum;
            r_sum_s2    <= r_sum_s1;
            r_rest_s1   <= bus.rest;
            r_rest_s2   <= r_rest_s1;
            r_warm      <= {r_warm[0], 1'b1};
            r_sum_prev  <= r_warm[1] & r_sum_s2;
            r_rest_prev <= r_warm[1] & r_rest_s2;
        end
    end

    assign w_sum_fall  = r_sum_prev  & ~r_sum_s2;
    assign w_rest_fall = r_rest_prev & ~r_rest_s2;
    assign w_step_up   = w_sum_fall  & ~w_rest_fall;
    assign w_step_dn   = w_rest_fall & ~w_sum_fall;

    // ---------------- channel select / next duty ----------------
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_duty  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.ch_sel == SEL_BITS'(c)) begin
                w_sel_valid = 1'b1;
                w_sel_duty  = r_shadow[c];
            end
        end
    end

    always_comb begin
        w_next_duty = w_sel_duty;
        if (w_step_up) begin
            w_next_duty = sat_inc(w_sel_duty);
        end else if (w_step_dn) begin
            w_next_duty = sat_dec(w_sel_duty);
        end
    end

    // Saturated or invalid steps leave the duty equal and so raise no enaSel.
    assign w_duty_change = w_sel_valid & (w_next_duty != w_sel_duty);

    // ---------------- shadow / active duties, compare ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enaSel <= 1'b0;
            r_pwm    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_shadow[c] <= '0;
                r_active[c] <= '0;
            end
        end else begin
            r_enaSel <= w_duty_change;
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_duty_change && (bus.ch_sel == SEL_BITS'(c))) begin
                    r_shadow[c] <= w_next_duty;
                end
                // Non-blocking: an edit landing in the wrap cycle is not
                // transferred until the following period.
                if (w_wrap) begin
                    r_active[c] <= r_shadow[c];
                end
                r_pwm[c] <= (r_value < r_active[c]);
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.ena          = w_ena;
    assign bus.value        = r_value;
    assign bus.pwm_out      = r_pwm;
    assign bus.referencia   = w_sel_duty;
    assign bus.enaSel       = r_enaSel;
    assign bus.period_start = w_wrap;

endmodule
